// File: rtl/view_ctrl.sv
// Sprite/background draw sequencer: grants one request from IDLE, steps the pixel datapath, and aligns plot with it.
// Draw length is SPR_PIX or BG_PIX run cycles plus PIPE drain cycles. Requests are level-held and wait while busy.
module view_ctrl #(
  parameter int SPR_PIX = 256,
  parameter int BG_PIX  = 131072,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240,
  parameter int PIPE    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       bg_req,
  input  logic       spr_req,
  input  logic [8:0] spr_x,
  input  logic [7:0] spr_y,
  input  logic       spr_stone,
  output logic       bg_ack,
  output logic       spr_ack,
  output logic       busy,
  output logic       done,
  output logic [8:0] x_init,
  output logic [7:0] y_init,
  output logic       load_x,
  output logic       load_y,
  output logic       load_stone,
  output logic       resetn_c,
  output logic       enable_c,
  output logic       enable_x_adder,
  output logic       enable_y_adder,
  output logic       draw_background,
  output logic       plot
);

  typedef enum logic [2:0] {IDLE, LOAD, SPR_RUN, BG_RUN, DRAIN, DONE} state_t;

  localparam int SPR_CW = $clog2(SPR_PIX + 1);
  localparam int DRN_CW = $clog2(PIPE + 1);
  localparam logic [SPR_CW-1:0] SPR_LAST = SPR_CW'(SPR_PIX - 1);
  localparam logic [16:0]       BG_LAST  = 17'(BG_PIX - 1);
  localparam logic [DRN_CW-1:0] DRN_LAST = DRN_CW'(PIPE - 1);
  localparam logic [9:0]        W_LIM    = 10'(SCR_W);
  localparam logic [8:0]        H_LIM    = 9'(SCR_H);

  state_t            state, state_nxt;
  logic [SPR_CW-1:0] spr_cnt;
  logic [DRN_CW-1:0] drn_cnt;
  logic [16:0]       shadow;
  logic [PIPE-1:0]   dly;
  logic              stone_q;
  logic              pix_stb;
  logic              bg_vis;

  // Shadow counter mirrors the datapath background counter: x in [8:0], y in [16:9].
  assign bg_vis = ({1'b0, shadow[8:0]} < W_LIM) && ({1'b0, shadow[16:9]} < H_LIM);

  always_comb begin
    state_nxt       = state;
    bg_ack          = 1'b0;
    spr_ack         = 1'b0;
    load_x          = 1'b0;
    load_y          = 1'b0;
    resetn_c        = 1'b1;
    enable_c        = 1'b0;
    enable_x_adder  = 1'b0;
    enable_y_adder  = 1'b0;
    draw_background = 1'b0;
    pix_stb         = 1'b0;
    case (state)
      IDLE: begin
        resetn_c = 1'b0;
        if (bg_req) begin
          bg_ack    = 1'b1;
          state_nxt = BG_RUN;
        end else if (spr_req) begin
          spr_ack   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_x    = 1'b1;
        load_y    = 1'b1;
        resetn_c  = 1'b0;
        state_nxt = SPR_RUN;
      end
      SPR_RUN: begin
        enable_c       = 1'b1;
        enable_x_adder = 1'b1;
        enable_y_adder = 1'b1;
        pix_stb        = 1'b1;
        if (spr_cnt == SPR_LAST) state_nxt = DRAIN;
      end
      BG_RUN: begin
        draw_background = 1'b1;
        enable_x_adder  = 1'b1;
        enable_y_adder  = 1'b1;
        pix_stb         = bg_vis;
        if (shadow == BG_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drn_cnt == DRN_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign plot       = dly[PIPE-1];
  // Selected sprite is visible on the grant cycle itself, then held from the register.
  assign load_stone = spr_ack ? spr_stone : stone_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spr_cnt <= '0;
      drn_cnt <= '0;
      shadow  <= '0;
    end else begin
      spr_cnt <= (state == SPR_RUN && spr_cnt != SPR_LAST) ? spr_cnt + 1'b1 : '0;
      drn_cnt <= (state == DRAIN && drn_cnt != DRN_LAST) ? drn_cnt + 1'b1 : '0;
      if (state == BG_RUN) shadow <= (shadow == BG_LAST) ? '0 : shadow + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dly <= '0;
    end else begin
      dly[0] <= pix_stb;
      for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_init  <= '0;
      y_init  <= '0;
      stone_q <= 1'b0;
    end else if (spr_ack) begin
      x_init  <= spr_x;
      y_init  <= spr_y;
      stone_q <= spr_stone;
    end else if (bg_ack || state == DONE) begin
      stone_q <= 1'b0;
    end
  end

endmodule
